// File: rtl/adder_share_pkg.sv
// Shared constants, types and helpers for the shared add/subtract controller.
package adder_share_pkg;

    localparam int unsigned NUM_REQ_DEF = 4;
    localparam int unsigned WIDTH_DEF   = 32;
    localparam int unsigned ID_W_DEF    = $clog2(NUM_REQ_DEF);

    typedef logic [ID_W_DEF-1:0] req_id_t;

    typedef struct packed {
        logic carry;
        logic overflow;
        logic zero;
    } flags_t;

    // Round-robin successor of ptr among n requesters.
    function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned n);
        return (ptr + 32'd1 >= n) ? 32'd0 : ptr + 32'd1;
    endfunction

endpackage

// File: rtl/adder_share_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter: first request after i_ptr wins, with wrap.
module rr_arbiter
    import adder_share_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] i_req,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_grant_idx,
    output logic               o_any
);

    logic [ID_W-1:0] w_cand;

    always_comb begin
        o_grant     = '0;
        o_grant_idx = '0;
        o_any       = 1'b0;
        w_cand      = i_ptr;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            w_cand = ID_W'(next_ptr(32'(w_cand), NUM_REQ));
            if (!o_any && i_req[w_cand]) begin
                o_any       = 1'b1;
                o_grant_idx = w_cand;
            end
        end
        if (o_any) begin
            o_grant[o_grant_idx] = 1'b1;
        end
    end

endmodule

// File: rtl/adder_share_ctrl.sv
// One 32-bit add/subtract datapath shared by NUM_REQ requesters through a
// round-robin arbiter and a single-entry registered response stage.
module adder_share_ctrl
    import adder_share_pkg::*;
#(
    parameter  int unsigned NUM_REQ = NUM_REQ_DEF,
    parameter  int unsigned WIDTH   = WIDTH_DEF,
    localparam int unsigned ID_W    = $clog2(NUM_REQ)
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic [NUM_REQ-1:0]       req_valid,
    output logic [NUM_REQ-1:0]       req_ready,
    input  logic [NUM_REQ*WIDTH-1:0] req_a,
    input  logic [NUM_REQ*WIDTH-1:0] req_b,
    input  logic [NUM_REQ-1:0]       req_sub,
    output logic                     rsp_valid,
    input  logic                     rsp_ready,
    output logic [ID_W-1:0]          rsp_id,
    output logic [WIDTH-1:0]         rsp_sum,
    output logic                     rsp_carry,
    output logic                     rsp_overflow,
    output logic                     rsp_zero
);

    localparam int unsigned SUM_W = WIDTH + 1;

    logic               w_can_accept;
    logic [NUM_REQ-1:0] w_arb_req;
    logic [NUM_REQ-1:0] w_grant;
    logic [ID_W-1:0]    w_gidx;
    logic               w_xfer;
    logic [WIDTH-1:0]   w_a;
    logic [WIDTH-1:0]   w_b;
    logic [WIDTH-1:0]   w_b_eff;
    logic [WIDTH-1:0]   w_sum;
    logic               w_sub;
    logic               w_carry;
    flags_t             w_flags;

    logic               r_rsp_valid;
    logic [ID_W-1:0]    r_rsp_id;
    logic [WIDTH-1:0]   r_rsp_sum;
    flags_t             r_flags;
    logic [ID_W-1:0]    r_ptr;

    // Grants only while the response slot is free or draining, and never in reset.
    assign w_can_accept = ~r_rsp_valid | rsp_ready;
    assign w_arb_req    = req_valid & {NUM_REQ{w_can_accept & rst_n}};

    rr_arbiter #(.NUM_REQ(NUM_REQ)) u_arb (
        .i_req       (w_arb_req),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_grant_idx (w_gidx),
        .o_any       (w_xfer)
    );

    assign req_ready = w_grant;

    // Subtract is A + ~B + 1; carry out of the MSB doubles as "no borrow".
    always_comb begin
        w_a     = req_a[32'(w_gidx) * WIDTH +: WIDTH];
        w_b     = req_b[32'(w_gidx) * WIDTH +: WIDTH];
        w_sub   = req_sub[w_gidx];
        w_b_eff = w_sub ? ~w_b : w_b;
        {w_carry, w_sum} = SUM_W'(w_a) + SUM_W'(w_b_eff) + SUM_W'(w_sub);
        w_flags.carry    = w_carry;
        w_flags.overflow = (w_a[WIDTH-1] == w_b_eff[WIDTH-1]) && (w_sum[WIDTH-1] != w_a[WIDTH-1]);
        w_flags.zero     = (w_sum == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rsp_valid <= 1'b0;
            r_rsp_id    <= '0;
            r_rsp_sum   <= '0;
            r_flags     <= '0;
            r_ptr       <= ID_W'(NUM_REQ - 1);
        end else if (w_xfer) begin
            r_rsp_valid <= 1'b1;
            r_rsp_id    <= w_gidx;
            r_rsp_sum   <= w_sum;
            r_flags     <= w_flags;
            r_ptr       <= w_gidx;
        end else if (rsp_ready) begin
            r_rsp_valid <= 1'b0;
        end
    end

    assign rsp_valid    = r_rsp_valid;
    assign rsp_id       = r_rsp_id;
    assign rsp_sum      = r_rsp_sum;
    assign rsp_carry    = r_flags.carry;
    assign rsp_overflow = r_flags.overflow;
    assign rsp_zero     = r_flags.zero;

endmodule

// File: doc/adder_share_ctrl.md
Name: adder_share_ctrl

Overview:
- Shares one 32-bit add/subtract datapath among NUM_REQ requesters.
- Uses round-robin arbitration, a valid/ready handshake on each request port and a single-entry registered response stage.
- Sits between the lab ALU clients (e.g. address, counter and accumulator units) and the shared adder. Each client gets sum plus carry, overflow and zero flags, tagged with the requester ID.

Parameters:
- NUM_REQ, 4, number of requester ports (2..8)
- WIDTH, 32, operand/result width in bits

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_ready  out  NUM_REQ  per-requester grant/accept (one-hot or zero)
- req_a  in  NUM_REQ*WIDTH  operand A, requester i at bits [i*WIDTH +: WIDTH]
- req_b  in  NUM_REQ*WIDTH  operand B, same packing
- req_sub  in  NUM_REQ  1 = compute A-B, 0 = A+B
- rsp_valid  out  1  response register holds a result
- rsp_ready  in  1  consumer accepts response
- rsp_id  out  $clog2(NUM_REQ)  index of requester that produced the result
- rsp_sum  out  WIDTH  result
- rsp_carry  out  1  carry out of MSB (for subtract: 1 = no borrow)
- rsp_overflow  out  1  two's-complement signed overflow
- rsp_zero  out  1  rsp_sum == 0, independent of the other flags

Behaviour:
- Reset (async assert, sync release):
  - rsp_valid=0; rsp_id, rsp_sum and all flags = 0.
  - RR pointer = NUM_REQ-1, so requester 0 has first priority.
  - req_ready all 0 while rst_n=0.
- Accept condition: can_accept = !rsp_valid | rsp_ready.
- Arbitration (combinational, each cycle):
  - If can_accept, grant the first requester with req_valid=1, searching from (ptr+1) mod NUM_REQ upward with wrap.
  - req_ready[g]=1 for the winner only; all others 0.
  - If !can_accept or no valid request, req_ready = 0.
- Handshake:
  - A request transfers when req_valid[i] & req_ready[i].
  - req_ready may depend on req_valid.
  - Requesters must hold valid and operands stable until the transfer. The block does not check this.
- On transfer (clock edge):
  - Datapath computes B' = sub ? ~B : B, cin = sub, and {carry, sum} = A + B' + cin, at WIDTH+1 bits.
  - overflow = (A[MSB] == B'[MSB]) & (sum[MSB] != A[MSB]).
  - zero = (sum == 0).
  - Registers sum, flags and id = g; sets rsp_valid=1; ptr <= g.
- Latency: exactly 1 cycle from transfer to rsp_valid.
- Throughput: 1 result per cycle while rsp_ready=1.
- Response drain: if rsp_valid & rsp_ready and there is no new transfer, rsp_valid <= 0.
  - Simultaneous drain plus new transfer: the register is overwritten with the new result and rsp_valid stays 1.
- Backpressure: if rsp_valid & !rsp_ready:
  - all response outputs hold stable;
  - no grants;
  - ptr unchanged.
- Fairness: a requester that holds valid is granted within NUM_REQ accepted transfers.
- ptr changes only on a transfer. Idle cycles do not advance it.
- Reset mid-operation: any pending response is discarded immediately (rsp_valid drops asynchronously); ptr returns to NUM_REQ-1.
- Operand wrap: results are modulo 2^WIDTH. Carry/overflow report wrap; it is never saturated.

Decomposition:
- Package adder_share_pkg:
  - default constants NUM_REQ_DEF=4, WIDTH_DEF=32;
  - typedef for requester ID;
  - packed struct for flags {carry, overflow, zero};
  - function for the next-pointer wrap.
- Sub-module rr_arbiter: NUM_REQ request vector plus ptr in, one-hot grant and grant index out, purely combinational.
- Add/subtract and flag logic stays in the top level, feeding the response register.

Test Plan:
- Reset: assert rst_n=0 mid-traffic with rsp_valid=1 -> rsp_valid=0, req_ready=0 immediately; after release, with all four valid, the first grant is requester 0.
- Add wrap, zero: req0 A=0xFFFFFFFF B=0x00000001 sub=0 -> next cycle rsp_id=0, sum=0x00000000, carry=1, overflow=0, zero=1.
- Signed overflow add: req2 A=0x7FFFFFFF B=0x00000001 -> sum=0x80000000, carry=0, overflow=1, zero=0.
- Subtract: req1 A=0x80000000 B=0x00000001 sub=1 -> sum=0x7FFFFFFF, carry=1, overflow=1; A=0x5 B=0x7 sub=1 -> sum=0xFFFFFFFE, carry=0, overflow=0.
- Round robin: all 4 valid continuously, rsp_ready=1 -> rsp_id sequence 0,1,2,3,0,1 on consecutive cycles; with only req1 and req3 valid -> 1,3,1,3.
- Backpressure: rsp_ready=0 for 3 cycles with a response pending -> rsp_* stable, req_ready=0, no loss; after rsp_ready=1, ids continue the round-robin order without skips or duplicates.
